looped_nand: RTL and testbench
==============================

# looped_nand

Single-bit (width-parameterised) sequential toggle/force cell: a NAND gate whose second input is its own output, registered for one cycle. When `a` is high the stored state inverts every cycle; when `a` is low the state is forced to 1. It is a minimal feedback-through-register primitive for exercising registered loops in generated netlists.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of `a`, `b` and `c`. All operations are bitwise and independent per bit.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  WIDTH  control input. 1 means toggle the state; 0 means force the state to 1.
- `b`  output  WIDTH  combinational NAND output: `~(a & c)`.
- `c`  output  WIDTH  registered loop state: the value of `b` captured at the previous clock edge.

## Operation
- One state register `c` (WIDTH bits).
- Gate: `b = ~(a & c)`. This is purely combinational, bitwise, with no other logic in the path.
- Register update at each `posedge clk`:
  - if `rst` = 1: `c <= 0` (all bits);
  - else: `c <= b`.
- Per-bit behaviour when not in reset:
  - `a`=1: `c` toggles every cycle, because `c_next = ~c`.
  - `a`=0: `c_next` = 1 regardless of the current state (force-1).
- `b` is a pure combinational function of the current `a` and `c`. It is never registered separately.
- There is no combinational loop: the feedback path always passes through `c`.

## Timing
- Reset:
  - `c` = 0 from the first rising edge sampled with `rst`=1, and it stays 0 while `rst` is held.
  - During reset, `b` = `~(a & 0)` = all ones. It is not forced by reset logic; this value results from `c`=0.
- Latency:
  - `a` to `b`: 0 cycles (combinational).
  - `b` to `c`: 1 cycle.
- First edge after `rst` deasserts: `c` captures `b` as normal. There is no extra dead cycle.
- Reset mid-operation: asserting `rst` overrides the loop at the next edge (`c` <= 0) whatever the value of `a`. After release, the sequence restarts from `c`=0.
- `rst` and `a` changing in the same cycle: `rst` has priority; `a` affects only `b` during that cycle.
- State before the first reset edge is undefined (X). Benches must apply reset for at least 1 edge.
- `a` must be stable around `posedge clk` (standard setup/hold). It has no other handshake.

## Test plan
- Reset: hold `rst`=1 for 1 edge with `a`=0, then release.
  - Required: `c`=0, `b`=1.
- Force after reset: `a`=0 for 2 cycles.
  - Required: `c` sequence 0→1→1, with `b`=1 throughout.
- Toggle: with `c`=1, set `a`=1 for 4 cycles.
  - Required `c` per edge: 1,0,1,0,1.
  - Required `b`: 0,1,0,1 (`b` is always `~c`).
- Force interrupting toggle: from `c`=0 with `a`=1, set `a`=0 for 3 cycles, then `a`=1 for 3 cycles.
  - Required: `c` goes to 1 and holds at 1 for 3 cycles.
  - Then `c` = 0,1,0.
- Reset mid-toggle: with `a`=1 and `c` toggling, pulse `rst`=1 for one edge.
  - Required: `c`=0 after that edge and `b`=1 during reset.
  - After release, toggling resumes from 0: 0→1→0.
- Bitwise independence (`WIDTH`=4): after reset (`c`=4'b0000), hold `a`=4'b1010 for 2 edges.
  - Required: `c` = 4'b1111 after the first edge.
  - Required: `c` = 4'b0101 after the second edge.

Source files
------------

// File: rtl/looped_nand.sv
`default_nettype none
// ============================================================================
// Module      : looped_nand
// Description : Registered NAND feedback cell. Each bit toggles while a=1 and
//               is forced to 1 while a=0. State clears on synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module looped_nand #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] w_nand;

    // The feedback path is broken by r_c, so no combinational loop exists.
    assign w_nand = ~(a & r_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c <= '0;
        end else begin
            r_c <= w_nand;
        end
    end

    assign b = w_nand;
    assign c = r_c;

endmodule
`default_nettype wire

// File: tb/tb_looped_nand.sv
`default_nettype none
// ============================================================================
// Module      : tb_looped_nand
// Description : Directed self-checking bench for looped_nand (WIDTH 1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_looped_nand;

    logic       clk;
    logic       rst;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] c1;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [3:0] c4;

    int n_checks;
    int n_fail;

    looped_nand #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .a   (a1),
        .b   (b1),
        .c   (c1)
    );

    looped_nand #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .a   (a4),
        .b   (b4),
        .c   (c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a1  = 1'b0;
        a4  = 4'b0000;

        // Reset
        tick();
        check("rst_c1", 32'(c1), 32'd0);
        check("rst_b1", 32'(b1), 32'd1);
        check("rst_c4", 32'(c4), 32'h0);
        check("rst_b4", 32'(b4), 32'hF);
        rst = 1'b0;

        // Force after reset: c 0 -> 1 -> 1
        tick();
        check("force_c_e1", 32'(c1), 32'd1);
        check("force_b_e1", 32'(b1), 32'd1);
        tick();
        check("force_c_e2", 32'(c1), 32'd1);
        check("force_b_e2", 32'(b1), 32'd1);

        // Toggle from c=1
        a1 = 1'b1;
        #1;
        check("tog_b0", 32'(b1), 32'd0);
        tick();
        check("tog_c_e1", 32'(c1), 32'd0);
        check("tog_b_e1", 32'(b1), 32'd1);
        tick();
        check("tog_c_e2", 32'(c1), 32'd1);
        check("tog_b_e2", 32'(b1), 32'd0);
        tick();
        check("tog_c_e3", 32'(c1), 32'd0);
        tick();
        check("tog_c_e4", 32'(c1), 32'd1);

        // Reach c=0, then force interrupts toggling
        tick();
        check("intr_c_start", 32'(c1), 32'd0);
        a1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("intr_force_c%0d", i), 32'(c1), 32'd1);
        end
        a1 = 1'b1;
        tick();
        check("intr_tog_c0", 32'(c1), 32'd0);
        tick();
        check("intr_tog_c1", 32'(c1), 32'd1);
        tick();
        check("intr_tog_c2", 32'(c1), 32'd0);

        // Reset in the middle of toggling
        tick();
        check("mid_pre_c", 32'(c1), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_pre_b", 32'(b1), 32'd0);
        tick();
        check("mid_rst_c", 32'(c1), 32'd0);
        check("mid_rst_b", 32'(b1), 32'd1);
        rst = 1'b0;
        tick();
        check("mid_rel_c1", 32'(c1), 32'd1);
        tick();
        check("mid_rel_c2", 32'(c1), 32'd0);

        // Bitwise independence on the 4-bit instance
        rst = 1'b1;
        a4  = 4'b0000;
        tick();
        check("w4_rst_c", 32'(c4), 32'h0);
        rst = 1'b0;
        a4  = 4'b1010;
        #1;
        check("w4_b0", 32'(b4), 32'hF);
        tick();
        check("w4_c_e1", 32'(c4), 32'hF);
        check("w4_b_e1", 32'(b4), 32'h5);
        tick();
        check("w4_c_e2", 32'(c4), 32'h5);
        check("w4_b_e2", 32'(b4), 32'hF);

        // Reset takes priority over a changing in the same cycle
        rst = 1'b1;
        a4  = 4'b1111;
        #1;
        check("w4_prio_b", 32'(b4), 32'hA);
        tick();
        check("w4_prio_c", 32'(c4), 32'h0);
        check("w4_prio_b2", 32'(b4), 32'hF);
        rst = 1'b0;
        tick();
        check("w4_after_c", 32'(c4), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
